// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width/limit, digit type, per-edge operation
// encoding and the flag bundle registered by the counter.
package bcd_pkg;

  localparam int DIGIT_W   = 4;
  localparam int DIGIT_MAX = 9;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLR   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_COUNT = 2'd3
  } bcd_op_t;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic load_err;
  } bcd_flags_t;

  function automatic logic is_valid_bcd(bcd_digit_t d);
    return d <= bcd_digit_t'(DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Signal bundle around one BCD up/down counter; master drives controls,
// slave is the counter side.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 4
);
  import bcd_pkg::*;

  logic                       clr;
  logic                       load;
  logic [DIGIT_W*DIGITS-1:0]  load_val;
  logic                       en;
  logic                       up;
  logic [DIGIT_W*DIGITS-1:0]  count;
  logic                       tc;
  logic                       ovf;
  logic                       unf;
  logic                       load_err;

  modport master (
    output clr, load, load_val, en, up,
    input  count, tc, ovf, unf, load_err
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output count, tc, ovf, unf, load_err
  );

endinterface

// File: rtl/bcd_digit.sv
// Combinational single-digit BCD step: one increment or decrement when
// step_in is set, with step_out flagging the 9->0 carry or 0->9 borrow.
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       step_in,
  input  logic       up,
  output bcd_digit_t digit_next,
  output logic       step_out
);

  always_comb begin
    digit_next = digit;
    step_out   = 1'b0;
    if (step_in) begin
      if (up) begin
        if (digit >= bcd_digit_t'(DIGIT_MAX)) begin
          digit_next = '0;
          step_out   = 1'b1;
        end else begin
          digit_next = digit + bcd_digit_t'(1);
        end
      end else begin
        if (digit == '0) begin
          digit_next = bcd_digit_t'(DIGIT_MAX);
          step_out   = 1'b1;
        end else begin
          digit_next = digit - bcd_digit_t'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clear, checked parallel load,
// wrap or saturate at the boundaries, and registered event pulses.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  input  logic                      en,
  input  logic                      up,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic                      tc,
  output logic                      ovf,
  output logic                      unf,
  output logic                      load_err
);

  localparam int CW = DIGIT_W * DIGITS;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_updown_counter: DIGITS must be within 1..8");
  end

  logic [CW-1:0]   count_next;
  logic [DIGITS:0] carry;
  logic            load_ok;
  logic            boundary;
  bcd_op_t         op;
  bcd_flags_t      flags_q;

  // The units digit always sees a step; the final carry/borrow out of the
  // top digit therefore means the count sits on the boundary for this direction.
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .digit      (count[g*DIGIT_W +: DIGIT_W]),
      .step_in    (carry[g]),
      .up         (up),
      .digit_next (count_next[g*DIGIT_W +: DIGIT_W]),
      .step_out   (carry[g+1])
    );
  end

  assign boundary = carry[DIGITS];

  always_comb begin
    load_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_valid_bcd(load_val[i*DIGIT_W +: DIGIT_W])) load_ok = 1'b0;
    end
  end

  always_comb begin
    if (clr)       op = OP_CLR;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_COUNT;
    else           op = OP_HOLD;
  end

  assign tc = (op == OP_COUNT) && boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      flags_q <= '0;
    end else begin
      unique case (op)
        OP_CLR: begin
          count   <= '0;
          flags_q <= '0;
        end
        OP_LOAD: begin
          if (load_ok) count <= load_val;
          flags_q <= '{ovf: 1'b0, unf: 1'b0, load_err: !load_ok};
        end
        OP_COUNT: begin
          // Saturation is simply a suppressed update at the boundary.
          if (WRAP || !boundary) count <= count_next;
          flags_q <= '{ovf: boundary && up, unf: boundary && !up, load_err: 1'b0};
        end
        OP_HOLD: begin
          flags_q <= '0;
        end
        default: begin
          flags_q <= '0;
        end
      endcase
    end
  end

  assign ovf      = flags_q.ovf;
  assign unf      = flags_q.unf;
  assign load_err = flags_q.load_err;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: four builds (4/wrap, 4/saturate, 1/wrap,
// 8/wrap) share one stimulus stream and are checked against a decimal model.
module tb_bcd_updown_counter;

  logic        clk;
  logic        rst_n;
  logic        clr, load, en, up;
  logic [31:0] lv;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_updown_counter_if #(.DIGITS(4)) ia ();
  bcd_updown_counter_if #(.DIGITS(4)) ib ();
  bcd_updown_counter_if #(.DIGITS(1)) ic ();
  bcd_updown_counter_if #(.DIGITS(8)) id ();

  assign ia.clr = clr;  assign ia.load = load;  assign ia.en = en;  assign ia.up = up;
  assign ib.clr = clr;  assign ib.load = load;  assign ib.en = en;  assign ib.up = up;
  assign ic.clr = clr;  assign ic.load = load;  assign ic.en = en;  assign ic.up = up;
  assign id.clr = clr;  assign id.load = load;  assign id.en = en;  assign id.up = up;
  assign ia.load_val = lv[15:0];
  assign ib.load_val = lv[15:0];
  assign ic.load_val = lv[3:0];
  assign id.load_val = lv;

  bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(ia.clr), .load(ia.load), .load_val(ia.load_val),
    .en(ia.en), .up(ia.up), .count(ia.count), .tc(ia.tc), .ovf(ia.ovf),
    .unf(ia.unf), .load_err(ia.load_err));
  bcd_updown_counter #(.DIGITS(4), .WRAP(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(ib.clr), .load(ib.load), .load_val(ib.load_val),
    .en(ib.en), .up(ib.up), .count(ib.count), .tc(ib.tc), .ovf(ib.ovf),
    .unf(ib.unf), .load_err(ib.load_err));
  bcd_updown_counter #(.DIGITS(1), .WRAP(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(ic.clr), .load(ic.load), .load_val(ic.load_val),
    .en(ic.en), .up(ic.up), .count(ic.count), .tc(ic.tc), .ovf(ic.ovf),
    .unf(ic.unf), .load_err(ic.load_err));
  bcd_updown_counter #(.DIGITS(8), .WRAP(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n), .clr(id.clr), .load(id.load), .load_val(id.load_val),
    .en(id.en), .up(id.up), .count(id.count), .tc(id.tc), .ovf(id.ovf),
    .unf(id.unf), .load_err(id.load_err));

  logic [31:0] d_cnt [4];
  logic        d_tc  [4];
  logic        d_ovf [4];
  logic        d_unf [4];
  logic        d_le  [4];

  always_comb begin
    d_cnt[0] = 32'(ia.count); d_tc[0] = ia.tc; d_ovf[0] = ia.ovf; d_unf[0] = ia.unf; d_le[0] = ia.load_err;
    d_cnt[1] = 32'(ib.count); d_tc[1] = ib.tc; d_ovf[1] = ib.ovf; d_unf[1] = ib.unf; d_le[1] = ib.load_err;
    d_cnt[2] = 32'(ic.count); d_tc[2] = ic.tc; d_ovf[2] = ic.ovf; d_unf[2] = ic.unf; d_le[2] = ic.load_err;
    d_cnt[3] = 32'(id.count); d_tc[3] = id.tc; d_ovf[3] = id.ovf; d_unf[3] = id.unf; d_le[3] = id.load_err;
  end

  // ---------------- behavioural model (plain decimal arithmetic) ----------------
  typedef struct {
    logic [31:0] c;
    bit          o;
    bit          u;
    bit          e;
  } mres_t;

  function automatic int nd(int k);
    case (k)
      0, 1:    return 4;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic bit nw(int k);
    return k != 1;
  endfunction

  function automatic longint bcd2int(logic [31:0] v, int d);
    longint r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(longint x, int d);
    logic [31:0] r = '0;
    longint      y = x;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  function automatic longint maxv(int d);
    longint m = 1;
    for (int i = 0; i < d; i++) m = m * 10;
    return m - 1;
  endfunction

  function automatic bit lv_ok(logic [31:0] v, int d);
    for (int i = 0; i < d; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic mres_t mstep(int d, bit w, logic [31:0] cur,
                                  bit c, bit l, logic [31:0] v, bit e, bit u);
    mres_t  r;
    longint x;
    longint mx;
    r.c = cur; r.o = 1'b0; r.u = 1'b0; r.e = 1'b0;
    x  = bcd2int(cur, d);
    mx = maxv(d);
    if (c) begin
      r.c = '0;
    end else if (l) begin
      if (lv_ok(v, d)) r.c = int2bcd(bcd2int(v, d), d);
      else             r.e = 1'b1;
    end else if (e) begin
      if (u) begin
        if (x == mx) begin r.o = 1'b1; if (w) r.c = '0; end
        else r.c = int2bcd(x + 1, d);
      end else begin
        if (x == 0) begin r.u = 1'b1; if (w) r.c = int2bcd(mx, d); end
        else r.c = int2bcd(x - 1, d);
      end
    end
    return r;
  endfunction

  logic [31:0] m_cnt [4];
  logic        m_ovf [4];
  logic        m_unf [4];
  logic        m_le  [4];

  always @(posedge clk or negedge rst_n) begin
    mres_t r;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_cnt[k] <= '0; m_ovf[k] <= 1'b0; m_unf[k] <= 1'b0; m_le[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        r = mstep(nd(k), nw(k), m_cnt[k], clr, load, lv, en, up);
        m_cnt[k] <= r.c; m_ovf[k] <= r.o; m_unf[k] <= r.u; m_le[k] <= r.e;
      end
    end
  end

  function automatic bit model_tc(int k);
    longint x = bcd2int(m_cnt[k], nd(k));
    return en && !clr && !load && (up ? (x == maxv(nd(k))) : (x == 0));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("count[%0d]", k), d_cnt[k], m_cnt[k]);
      chk($sformatf("tc[%0d]", k), 32'(d_tc[k]), 32'(model_tc(k)));
      chk($sformatf("ovf[%0d]", k), 32'(d_ovf[k]), 32'(m_ovf[k]));
      chk($sformatf("unf[%0d]", k), 32'(d_unf[k]), 32'(m_unf[k]));
      chk($sformatf("load_err[%0d]", k), 32'(d_le[k]), 32'(m_le[k]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] prev;
  int          mode;

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1; lv = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_count", d_cnt[0], 32'h0);
    chk("rst_tc_up", 32'(d_tc[0]), 32'h0);
    up = 1'b0; #1;
    chk("rst_tc_down", 32'(d_tc[0]), 32'h1);
    up = 1'b1; #1;
    rst_n = 1'b1;

    repeat (12) cyc();
    chk("count12", d_cnt[0], 32'h0012);

    load = 1'b1; lv = 32'h9998; cyc(); load = 1'b0;
    chk("load9998", d_cnt[0], 32'h9998);
    cyc();
    chk("at9999", d_cnt[0], 32'h9999);
    chk("tc9999", 32'(d_tc[0]), 32'h1);
    cyc();
    chk("wrap0", d_cnt[0], 32'h0000);
    chk("wrap_ovf", 32'(d_ovf[0]), 32'h1);
    chk("sat9999", d_cnt[1], 32'h9999);
    chk("sat_ovf", 32'(d_ovf[1]), 32'h1);
    cyc();
    chk("after_wrap", d_cnt[0], 32'h0001);
    chk("ovf_single", 32'(d_ovf[0]), 32'h0);

    load = 1'b1; lv = 32'h0001; up = 1'b0; cyc(); load = 1'b0;
    cyc();
    chk("down0", d_cnt[1], 32'h0000);
    chk("down0_unf", 32'(d_unf[1]), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("sat_hold0", d_cnt[1], 32'h0000);
      chk("sat_unf", 32'(d_unf[1]), 32'h1);
    end

    en = 1'b0; prev = d_cnt[0];
    load = 1'b1; lv = 32'h12A4; cyc(); load = 1'b0;
    chk("bad_load_hold", d_cnt[0], prev);
    chk("bad_load_err", 32'(d_le[0]), 32'h1);
    cyc();
    chk("load_err_single", 32'(d_le[0]), 32'h0);
    clr = 1'b1; load = 1'b1; lv = 32'h1234; cyc(); clr = 1'b0; load = 1'b0;
    chk("clr_over_load", d_cnt[0], 32'h0000);

    en = 1'b1; up = 1'b0; load = 1'b1; lv = 32'h0100; cyc(); load = 1'b0;
    chk("load0100", d_cnt[0], 32'h0100);
    cyc();
    chk("double_borrow", d_cnt[0], 32'h0099);
    up = 1'b1; cyc();
    chk("up_toggle", d_cnt[0], 32'h0100);

    cyc(); #1;
    rst_n = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      chk("async_rst_cnt", d_cnt[k], 32'h0);
      chk("async_rst_flags", {29'h0, d_ovf[k], d_unf[k], d_le[k]}, 32'h0);
    end
    cyc(); rst_n = 1'b1;

    load = 1'b1; lv = 32'h99999999; cyc(); load = 1'b0;
    cyc();
    chk("d1_wrap", d_cnt[2], 32'h0);
    chk("d1_ovf", 32'(d_ovf[2]), 32'h1);
    chk("d8_wrap", d_cnt[3], 32'h0);
    chk("d8_ovf", 32'(d_ovf[3]), 32'h1);

    for (int n = 0; n < 3000; n++) begin
      clr  = ($urandom_range(0, 99) < 4);
      load = ($urandom_range(0, 99) < 10);
      en   = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 19) == 0) up = ~up;
      mode = $urandom_range(0, 3);
      case (mode)
        0: lv = $urandom();
        1: for (int i = 0; i < 8; i++) lv[4*i +: 4] = 4'($urandom_range(0, 9));
        2: lv = 32'h99999999;
        default: lv = 32'h0;
      endcase
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    clr = 1'b0; load = 1'b0; en = 1'b0;
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4, legal range 1..8, sets the number of BCD digits; the count width is 4*DIGITS bits.
REQ-002 Parameter WRAP, default 1: 1 = wrap at the boundaries, 0 = saturate at the boundaries.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port clr, input, 1 bit: synchronous clear to zero.
REQ-006 Port load, input, 1 bit: synchronous parallel load request.
REQ-007 Port load_val, input, 4*DIGITS bits: BCD value to load; nibble i is digit i, with nibble 0 the units digit.
REQ-008 Port en, input, 1 bit: count enable.
REQ-009 Port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-010 Port count, output, 4*DIGITS bits: registered BCD count; nibble 0 is the units digit.
REQ-011 Port tc, output, 1 bit: combinational terminal-count indication.
REQ-012 Port ovf, output, 1 bit: registered overflow pulse.
REQ-013 Port unf, output, 1 bit: registered underflow pulse.
REQ-014 Port load_err, output, 1 bit: registered invalid-load pulse.

Function
REQ-015 Each count nibble shall always hold a value in 0..9; no other value shall ever appear on count.
REQ-016 Per-edge priority shall be clr, then load, then en, then hold.
REQ-017 When clr=1, count shall become 0 on the next edge, and ovf, unf and load_err shall be 0 in the following cycle.
REQ-018 When load=1 and every load_val nibble is at most 9, count shall become load_val on the next edge.
REQ-019 When load=1 and any load_val nibble exceeds 9, count shall hold and load_err shall be 1 for exactly the following cycle.
REQ-020 When en=1 and up=1, count shall increment by one in decimal, with a carry from digit i into digit i+1 whenever digit i goes 9 -> 0, all within one edge.
REQ-021 When en=1 and up=0, count shall decrement by one in decimal, with a borrow whenever digit i goes 0 -> 9, all within one edge.
REQ-022 The count shall have a latency of 1: the new value is visible on count in the cycle after the qualifying edge.
REQ-023 When up=1 at all-9s with WRAP=1, count shall go to 0 and ovf shall be 1 for the next cycle.
REQ-024 When up=1 at all-9s with WRAP=0, count shall hold at all-9s and ovf shall be 1 for the next cycle.
REQ-025 When up=0 at zero with WRAP=1, count shall go to all-9s and unf shall be 1 for the next cycle.
REQ-026 When up=0 at zero with WRAP=0, count shall hold at zero and unf shall be 1 for the next cycle.
REQ-027 tc shall equal en & !clr & !load & (up ? count==all-9s : count==0), so that it can cascade into a further counter's en.
REQ-028 In every cycle where no event triggers them, ovf, unf and load_err shall be 0; each is a one-cycle pulse per event, and back-to-back events give back-to-back pulses.
REQ-029 When en=0 and no clr or load is active, count shall hold.
REQ-030 A change of up shall take effect on the same edge it is sampled; no dead cycle is allowed.

Reset
REQ-031 While rst_n=0, count, ovf, unf and load_err shall be 0 immediately, independent of clk.
REQ-032 If reset is asserted mid-operation, any pending load or count shall be discarded.
REQ-033 Reset deassertion shall be synchronised externally; the first edge after release shall behave normally.
REQ-034 tc shall follow REQ-027 from count=0 during and after reset.

Structure
REQ-035 A shared package bcd_pkg shall hold DIGIT_W=4, DIGIT_MAX=9, the bcd_digit_t typedef (4-bit logic) and the function is_valid_bcd(bcd_digit_t).
REQ-036 A sub-module bcd_digit shall be instantiated DIGITS times through a generate loop.
REQ-037 Each bcd_digit shall be a combinational single-digit step: inputs digit, step-in and up; outputs next digit and step-out; registers shall live in the top.
REQ-038 Saturation shall be resolved in the top by suppressing the update; the digit cell shall not contain it.

Verification (DIGITS=4 unless stated)
REQ-039 Reset with en=1, up=1, then 12 cycles -> count=0x0012, tc=0 throughout, no flags.
REQ-040 Load 0x9998, en=1, up=1, WRAP=1 -> 0x9999 with tc=1 -> 0x0000 with ovf=1 for one cycle -> 0x0001.
REQ-041 WRAP=0: load 0x0001, en=1, up=0 -> 0x0000, then held at 0x0000 for 3 cycles with unf=1 each cycle.
REQ-042 Load 0x12A4 -> count unchanged and load_err=1 for one cycle; then clr=1 and load=1 on the same edge -> count=0x0000.
REQ-043 Load 0x0100, en=1, up=0 -> 0x0099 (two borrows on one edge); toggle up the next cycle -> 0x0100.
REQ-044 Assert rst_n=0 between clock edges while counting -> count=0 and flags=0 immediately; DIGITS=1 and DIGITS=8 builds each pass the wrap test.
